// File: rtl/pipeline_trace_tracker.sv
// Shadow-tags WISC pipeline instructions with a sequence ID and fetch stamp through D/X/M/W slots.
// Optional TRACE_HLT_STOP_EN: freeze all tracking once an HLT (instr[15:12]=F) reaches W.
module pipeline_trace_tracker #(
   parameter int ID_W  = 8,
   parameter int CYC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic [15:0]      if_pc,
   input  logic [15:0]      if_instr,
   output logic [3:0]       stage_vld,
   output logic [ID_W-1:0]  d_id,
   output logic [ID_W-1:0]  x_id,
   output logic [ID_W-1:0]  m_id,
   output logic [ID_W-1:0]  w_id,
   output logic             ret_valid,
   output logic [ID_W-1:0]  ret_id,
   output logic [15:0]      ret_pc,
   output logic [15:0]      ret_instr,
   output logic [CYC_W-1:0] ret_fetch_cyc,
   output logic [CYC_W-1:0] ret_cyc,
   output logic [CYC_W-1:0] retired_cnt,
   output logic [CYC_W-1:0] squash_cnt,
   output logic             halted
);

   typedef struct packed {
      logic             vld;
      logic [ID_W-1:0]  id;
      logic [15:0]      pc;
      logic [15:0]      instr;
      logic [CYC_W-1:0] fcyc;
   } slot_t;

   slot_t            r_d, r_x, r_m, r_w;
   slot_t            w_d_nxt, w_x_nxt;
   logic [ID_W-1:0]  r_fetch_id, w_fetch_id_nxt;
   logic [CYC_W-1:0] r_cyc, r_ret_cnt, r_sq_cnt;
   logic             w_sq;
   logic             w_frz;

   // Stall beats flush: a held D cannot also be squashed.
   always_comb begin
      w_d_nxt        = r_d;
      w_x_nxt        = r_d;
      w_fetch_id_nxt = r_fetch_id;
      w_sq           = 1'b0;
      if (stall) begin
         w_x_nxt = '0;
      end else if (flush) begin
         w_d_nxt        = '0;
         w_fetch_id_nxt = r_fetch_id + ID_W'(1);
         w_sq           = 1'b1;
      end else begin
         w_d_nxt.vld    = 1'b1;
         w_d_nxt.id     = r_fetch_id;
         w_d_nxt.pc     = if_pc;
         w_d_nxt.instr  = if_instr;
         w_d_nxt.fcyc   = r_cyc;
         w_fetch_id_nxt = r_fetch_id + ID_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d        <= '0;
         r_x        <= '0;
         r_m        <= '0;
         r_w        <= '0;
         r_fetch_id <= '0;
         r_cyc      <= '0;
         r_ret_cnt  <= '0;
         r_sq_cnt   <= '0;
      end else if (w_frz) begin
         r_w.vld <= 1'b0;
      end else begin
         r_d        <= w_d_nxt;
         r_x        <= w_x_nxt;
         r_m        <= r_x;
         r_w        <= r_m;
         r_fetch_id <= w_fetch_id_nxt;
         r_cyc      <= r_cyc + CYC_W'(1);
         if (r_m.vld) r_ret_cnt <= r_ret_cnt + CYC_W'(1);
         if (w_sq)    r_sq_cnt  <= r_sq_cnt + CYC_W'(1);
      end
   end

`ifdef TRACE_HLT_STOP_EN
   logic r_halted;

   // Set on the same edge the HLT lands in W, so its retire strobe is still seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_halted <= 1'b0;
      else if (!r_halted && r_m.vld && (r_m.instr[15:12] == 4'hF))
         r_halted <= 1'b1;
   end

   assign w_frz  = r_halted;
   assign halted = r_halted;
`else
   assign w_frz  = 1'b0;
   assign halted = 1'b0;
`endif

   assign stage_vld     = {r_w.vld, r_m.vld, r_x.vld, r_d.vld};
   assign d_id          = r_d.id;
   assign x_id          = r_x.id;
   assign m_id          = r_m.id;
   assign w_id          = r_w.id;
   assign ret_valid     = r_w.vld;
   assign ret_id        = r_w.id;
   assign ret_pc        = r_w.pc;
   assign ret_instr     = r_w.instr;
   assign ret_fetch_cyc = r_w.fcyc;
   assign ret_cyc       = r_cyc;
   assign retired_cnt   = r_ret_cnt;
   assign squash_cnt    = r_sq_cnt;

endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Directed bench for pipeline_trace_tracker: clean flow, stall, flush, stall+flush, ID wrap, async reset, HLT.
module tb_pipeline_trace_tracker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, flush;
   logic [15:0] if_pc, if_instr;
   logic        zero_s;

   logic [3:0]  stage_vld;
   logic [7:0]  d_id, x_id, m_id, w_id, ret_id;
   logic        ret_valid, halted;
   logic [15:0] ret_pc, ret_instr;
   logic [31:0] ret_fetch_cyc, ret_cyc, retired_cnt, squash_cnt;

   logic [3:0]  b_stage_vld;
   logic [1:0]  b_d_id, b_x_id, b_m_id, b_w_id, b_ret_id;
   logic        b_ret_valid, b_halted;
   logic [15:0] b_ret_pc, b_ret_instr;
   logic [31:0] b_ret_fetch_cyc, b_ret_cyc, b_retired_cnt, b_squash_cnt;

   pipeline_trace_tracker #(.ID_W(8), .CYC_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_pc(if_pc), .if_instr(if_instr),
      .stage_vld(stage_vld), .d_id(d_id), .x_id(x_id), .m_id(m_id), .w_id(w_id),
      .ret_valid(ret_valid), .ret_id(ret_id), .ret_pc(ret_pc), .ret_instr(ret_instr),
      .ret_fetch_cyc(ret_fetch_cyc), .ret_cyc(ret_cyc),
      .retired_cnt(retired_cnt), .squash_cnt(squash_cnt), .halted(halted)
   );

   // Narrow-ID instance running a clean stream to exercise ID wrap.
   pipeline_trace_tracker #(.ID_W(2), .CYC_W(32)) dut_b (
      .clk(clk), .rst(rst), .stall(zero_s), .flush(zero_s),
      .if_pc(if_pc), .if_instr(if_instr),
      .stage_vld(b_stage_vld), .d_id(b_d_id), .x_id(b_x_id), .m_id(b_m_id), .w_id(b_w_id),
      .ret_valid(b_ret_valid), .ret_id(b_ret_id), .ret_pc(b_ret_pc), .ret_instr(b_ret_instr),
      .ret_fetch_cyc(b_ret_fetch_cyc), .ret_cyc(b_ret_cyc),
      .retired_cnt(b_retired_cnt), .squash_cnt(b_squash_cnt), .halted(b_halted)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int k       = 0;
   int hlt_k   = -1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one fetch cycle, then sample 1 time unit after the edge.
   task automatic tick(input bit st, input bit fl);
      stall    = st;
      flush    = fl;
      if_pc    = 16'(2 * k);
      if_instr = (k == hlt_k) ? 16'hF000 : (16'h1000 + 16'(k));
      @(posedge clk);
      #1;
      if (!st) k++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      zero_s = 1'b0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; if_pc = '0; if_instr = '0;
      #12;
      check("rst_stage_vld", stage_vld, 4'b0000);
      check("rst_ret_valid", ret_valid, 1'b0);
      check("rst_ret_cyc",   ret_cyc, 32'd0);
      check("rst_retired",   retired_cnt, 32'd0);
      check("rst_squash",    squash_cnt, 32'd0);
      check("rst_halted",    halted, 1'b0);
      @(negedge clk) rst = 1'b0;
      k = 0;

      tick(0, 0);  // e1
      check("e1_stage_vld", stage_vld, 4'b0001);
      check("e1_d_id", d_id, 8'd0);
      tick(0, 0);  // e2
      check("e2_stage_vld", stage_vld, 4'b0011);
      tick(0, 0);  // e3
      check("e3_stage_vld", stage_vld, 4'b0111);
      check("e3_d_id", d_id, 8'd2);
      check("e3_x_id", x_id, 8'd1);
      check("e3_m_id", m_id, 8'd0);
      tick(0, 0);  // e4: first retire
      check("e4_ret_valid", ret_valid, 1'b1);
      check("e4_ret_id", ret_id, 8'd0);
      check("e4_ret_pc", ret_pc, 16'h0000);
      check("e4_ret_instr", ret_instr, 16'h1000);
      check("e4_ret_fetch_cyc", ret_fetch_cyc, 32'd0);
      check("e4_ret_cyc", ret_cyc, 32'd4);
      check("e4_retired", retired_cnt, 32'd1);
      check("e4_stage_vld", stage_vld, 4'b1111);
      check("e4_b_ret_id", b_ret_id, 2'd0);
      check("e4_b_ret_valid", b_ret_valid, 1'b1);

      tick(1, 0);  // e5: stall with ID 3 in D
      check("e5_stage_vld", stage_vld, 4'b1101);
      check("e5_d_id", d_id, 8'd3);
      check("e5_ret_id", ret_id, 8'd1);
      check("e5_b_ret_id", b_ret_id, 2'd1);
      tick(1, 0);  // e6
      check("e6_stage_vld", stage_vld, 4'b1001);
      check("e6_d_id", d_id, 8'd3);
      check("e6_ret_id", ret_id, 8'd2);
      check("e6_b_ret_id", b_ret_id, 2'd2);
      tick(0, 0);  // e7: ID 4 captured
      check("e7_stage_vld", stage_vld, 4'b0011);
      check("e7_ret_valid", ret_valid, 1'b0);
      check("e7_b_ret_id", b_ret_id, 2'd3);
      tick(0, 1);  // e8: ID 5 squashed
      check("e8_squash", squash_cnt, 32'd1);
      check("e8_stage_vld", stage_vld, 4'b0110);
      check("e8_b_ret_id", b_ret_id, 2'd0);
      tick(0, 0);  // e9: ID 3 retires two cycles late
      check("e9_ret_valid", ret_valid, 1'b1);
      check("e9_ret_id", ret_id, 8'd3);
      check("e9_ret_pc", ret_pc, 16'h0006);
      check("e9_ret_fetch_cyc", ret_fetch_cyc, 32'd3);
      check("e9_ret_cyc", ret_cyc, 32'd9);
      check("e9_retired", retired_cnt, 32'd4);
      check("e9_d_id", d_id, 8'd6);
      check("e9_b_ret_id", b_ret_id, 2'd1);

      tick(1, 1);  // e10: stall+flush behaves as stall
      check("e10_ret_id", ret_id, 8'd4);
      check("e10_retired", retired_cnt, 32'd5);
      check("e10_squash", squash_cnt, 32'd1);
      check("e10_stage_vld", stage_vld, 4'b1001);
      check("e10_d_id", d_id, 8'd6);
      tick(0, 0);  // e11
      check("e11_ret_valid", ret_valid, 1'b0);
      check("e11_d_id", d_id, 8'd7);
      tick(0, 0);  // e12
      check("e12_ret_valid", ret_valid, 1'b0);
      tick(0, 0);  // e13: next retire after 4 is 6
      check("e13_ret_valid", ret_valid, 1'b1);
      check("e13_ret_id", ret_id, 8'd6);
      check("e13_ret_pc", ret_pc, 16'h000C);
      check("e13_ret_instr", ret_instr, 16'h1006);
      check("e13_ret_fetch_cyc", ret_fetch_cyc, 32'd8);
      check("e13_ret_cyc", ret_cyc, 32'd13);
      check("e13_retired", retired_cnt, 32'd6);
      check("e13_stage_vld", stage_vld, 4'b1111);
      check("e13_d_id", d_id, 8'd9);

      #2 rst = 1'b1;
      #1;
      check("arst_stage_vld", stage_vld, 4'b0000);
      check("arst_ret_valid", ret_valid, 1'b0);
      check("arst_ret_id", ret_id, 8'd0);
      check("arst_ret_pc", ret_pc, 16'h0000);
      check("arst_ret_fetch_cyc", ret_fetch_cyc, 32'd0);
      check("arst_ret_cyc", ret_cyc, 32'd0);
      check("arst_retired", retired_cnt, 32'd0);
      check("arst_squash", squash_cnt, 32'd0);
      check("arst_d_id", d_id, 8'd0);
      check("arst_w_id", w_id, 8'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      k = 0;
      hlt_k = 4;

      tick(0, 0);
      check("r1_ret_valid", ret_valid, 1'b0);
      tick(0, 0);
      check("r2_ret_valid", ret_valid, 1'b0);
      tick(0, 0);
      check("r3_ret_valid", ret_valid, 1'b0);
      tick(0, 0);
      check("r4_ret_valid", ret_valid, 1'b1);
      check("r4_ret_id", ret_id, 8'd0);
      check("r4_ret_cyc", ret_cyc, 32'd4);
      check("r4_retired", retired_cnt, 32'd1);
      tick(0, 0);  // e5: HLT fetched as ID 4
      tick(0, 0);
      tick(0, 0);
      tick(0, 0);  // e8: HLT in W
      check("h8_ret_valid", ret_valid, 1'b1);
      check("h8_ret_id", ret_id, 8'd4);
      check("h8_ret_instr", ret_instr, 16'hF000);
      check("h8_ret_cyc", ret_cyc, 32'd8);
      check("h8_retired", retired_cnt, 32'd5);
`ifdef TRACE_HLT_STOP_EN
      check("h8_halted", halted, 1'b1);
      tick(0, 0);
      check("h9_ret_valid", ret_valid, 1'b0);
      check("h9_ret_cyc", ret_cyc, 32'd8);
      check("h9_retired", retired_cnt, 32'd5);
      check("h9_halted", halted, 1'b1);
`else
      check("h8_halted", halted, 1'b0);
      tick(0, 0);
      check("h9_ret_valid", ret_valid, 1'b1);
      check("h9_ret_id", ret_id, 8'd5);
      check("h9_ret_cyc", ret_cyc, 32'd9);
      check("h9_retired", retired_cnt, 32'd6);
      check("h9_halted", halted, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipeline_trace_tracker.md
# pipeline_trace_tracker

Hardware tracker that tags every fetched instruction of the 5-stage WISC pipeline with a sequence ID and fetch-cycle stamp. It advances those tags through shadow ID/EX/MEM/WB slots using the same stall/flush rules as the datapath. It sits directly upstream of the per-instruction debug-print unit and supplies it with per-stage valid/ID and a registered retire record, replacing testbench-side ID bookkeeping.

## Interface
- ID_W, 8: sequence-ID width; wraps modulo 2^ID_W.
- CYC_W, 32: cycle-counter and stamp width; wraps modulo 2^CYC_W.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  PC/IF-ID hold; sampled on posedge.
- flush  in  1  squashes the instruction being fetched this cycle.
- if_pc  in  16  PC of the instruction in fetch.
- if_instr  in  16  instruction word in fetch.
- stage_vld  out  4  valid bits {W,M,X,D}.
- d_id, x_id, m_id, w_id  out  ID_W each  sequence ID held in each slot.
- ret_valid  out  1  registered retire strobe (W slot valid).
- ret_id  out  ID_W  ID of the retiring instruction.
- ret_pc, ret_instr  out  16 each  PC and word of the retiring instruction.
- ret_fetch_cyc  out  CYC_W  cycle stamp taken at fetch.
- ret_cyc  out  CYC_W  current cycle-counter value.
- retired_cnt, squash_cnt  out  CYC_W each  running totals.
- halted  out  1  see Configuration.

## Operation
- Slot contents for D/X/M/W: {valid, id, pc, instr, fcyc}. A bubble is valid=0; other fields are don't-care.
- cyc_cnt increments on every non-reset posedge.
- Update rules per posedge, evaluated in priority order:
  - stall=1, regardless of flush: D holds, fetch_id holds, X<=bubble, M<=X, W<=M.
  - else flush=1: D<=bubble, fetch_id<=fetch_id+1, squash_cnt+1, X<=D, M<=X, W<=M.
  - else: D<={1, fetch_id, if_pc, if_instr, cyc_cnt}, fetch_id+1, X<=D, M<=X, W<=M.
- retired_cnt increments on each posedge where W is loaded valid.
- ret_* fields come straight from the W slot. ret_valid = W.valid.
- Bubbles never produce ret_valid. The ID sequence seen at retire is monotonic mod 2^ID_W, with gaps only at squashed IDs.
- Wrap: fetch_id 2^ID_W-1 -> 0, cyc_cnt all-ones -> 0. No flag is raised on wrap.

## Timing
- Reset (async, immediate): all slot valids=0, all IDs=0, fetch_id=0, cyc_cnt=0, retired_cnt=0, squash_cnt=0, halted=0, every output 0.
- Reset asserted mid-operation discards all in-flight tags. No retire is emitted for them.
- Capture latency: an instruction captured into D at posedge N reaches W at posedge N+3 when no stall occurs. ret_valid is high for the cycle following N+3.
- Each stall cycle adds exactly one cycle of latency to the held D instruction.
- Stamps:
  - fcyc = cyc_cnt value before the capture edge.
  - First instruction after reset: ret_fetch_cyc=0, ret_cyc=4.
- stall and flush high together: stall wins and the flush is ignored.

## Configuration
- TRACE_HLT_STOP_EN defined:
  - When a valid instruction with instr[15:12]=4'hF is loaded into W, halted<=1 (sticky until reset).
  - After that, cyc_cnt, retired_cnt, squash_cnt, fetch_id and all slots freeze.
  - ret_valid deasserts one cycle after the HLT retire strobe.
- Undefined: halted tied 0. HLT is tracked like any other instruction.

## Test plan
- Reset then 6 clean fetches (pc 0x0000, 0x0002, ...): ret_valid first high after edge 4 with ret_id=0, ret_pc=0x0000, ret_fetch_cyc=0, ret_cyc=4. IDs 1..5 then retire on consecutive cycles.
- stall for 2 cycles with instr ID 3 in D: X receives 2 bubbles and ID 3 retires 2 cycles late. ret_fetch_cyc is unchanged and retired_cnt has no gaps.
- flush pulse for 1 cycle at fetch_id=5: ID 5 never retires, squash_cnt=1, and the next retired ID after 4 is 6.
- stall=1 and flush=1 in the same cycle: behaviour identical to stall alone and squash_cnt unchanged.
- Set ID_W=2 and run 6 instructions: retired IDs are 0,1,2,3,0,1.
- rst asserted asynchronously mid-cycle with 4 valid slots: all outputs 0 immediately with no retire; after release the next ret_id=0. With TRACE_HLT_STOP_EN, retiring 0xF000 sets halted=1 and cyc_cnt stops incrementing.
